// File: rtl/fetch_cycle.sv
// fetch_cycle: instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, assembles opcode+immediate instructions and loads the
// reset/interrupt vectors. It redirects on decode jumps and on write-back returns.
// Optional feature macro: FETCH_PERF_CNT_EN (adds the bubble_cnt output).
module fetch_cycle #(
  parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
  parameter logic [7:0] INT_VEC_ADDR   = 8'h01,
  parameter logic [3:0] IMM_OPC        = 4'hC,
  parameter logic [7:0] NOP_INSTR      = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       interrupt,
  input  logic       IR_en,
  input  logic       FlushD,
  input  logic       jmp_enD,
  input  logic [7:0] jmp_target,
  input  logic       RET_enWB,
  input  logic [7:0] ret_pc,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  output logic [7:0] instrD,
  output logic [7:0] pcD,
  output logic [7:0] Imm_D,
  output logic [7:0] int_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [7:0] bubble_cnt,
`endif
  output logic       int_ack
);

  localparam int unsigned AW = 8;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_IMM  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [AW-1:0] pc_inc;
  logic [7:0]    op_hold, op_hold_n;
  logic [AW-1:0] op_pc, op_pc_n;
  logic          pending, pending_n;
  logic [7:0]    instr_n, pcd_n, imm_n;
  logic [7:0]    int_pc_n;
  logic          int_ack_n;
  logic          bubble_c;

  assign pc_inc = AW'(pc + AW'(1));

  // Instruction memory address: vector slots in BOOT/INT, otherwise the PC
  always_comb begin
    imem_addr = pc;
    case (state)
      ST_BOOT: imem_addr = RESET_VEC_ADDR;
      ST_INT:  imem_addr = INT_VEC_ADDR;
      default: imem_addr = pc;
    endcase
  end

  // Next-state, PC and IF/ID payload selection in priority order
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    op_hold_n = op_hold;
    op_pc_n   = op_pc;
    pending_n = pending | interrupt;
    instr_n   = instrD;
    pcd_n     = pcD;
    imm_n     = Imm_D;
    int_pc_n  = int_pc;
    int_ack_n = 1'b0;
    bubble_c  = 1'b0;

    case (state)
      ST_BOOT: begin
        pc_n     = imem_rdata;
        state_n  = ST_RUN;
        bubble_c = 1'b1;
      end
      ST_INT: begin
        // A request arriving while the vector loads stays pending
        pc_n      = imem_rdata;
        pending_n = interrupt;
        state_n   = ST_RUN;
        bubble_c  = 1'b1;
      end
      default: begin
        if (RET_enWB) begin
          pc_n     = ret_pc;
          state_n  = ST_RUN;
          bubble_c = 1'b1;
        end else if (jmp_enD) begin
          pc_n     = jmp_target;
          state_n  = ST_RUN;
          bubble_c = 1'b1;
        end else if (state == ST_RUN && IR_en && pending) begin
          int_pc_n  = pc;
          int_ack_n = 1'b1;
          state_n   = ST_INT;
          bubble_c  = 1'b1;
        end else if (FlushD) begin
          // PC and state stay, so the same byte is fetched again
          bubble_c = 1'b1;
        end else if (IR_en) begin
          if (state == ST_IMM) begin
            instr_n = op_hold;
            pcd_n   = op_pc;
            imm_n   = imem_rdata;
            pc_n    = pc_inc;
            state_n = ST_RUN;
          end else if (imem_rdata[7:4] == IMM_OPC) begin
            op_hold_n = imem_rdata;
            op_pc_n   = pc;
            pc_n      = pc_inc;
            state_n   = ST_IMM;
            bubble_c  = 1'b1;
          end else begin
            instr_n = imem_rdata;
            pcd_n   = pc;
            imm_n   = 8'h00;
            pc_n    = pc_inc;
          end
        end
      end
    endcase

    // A bubble clears the whole IF/ID payload
    if (bubble_c) begin
      instr_n = NOP_INSTR;
      pcd_n   = 8'h00;
      imm_n   = 8'h00;
    end
  end

  // State, PC and IF/ID register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_BOOT;
      pc      <= '0;
      op_hold <= 8'h00;
      op_pc   <= '0;
      pending <= 1'b0;
      instrD  <= NOP_INSTR;
      pcD     <= 8'h00;
      Imm_D   <= 8'h00;
      int_pc  <= 8'h00;
      int_ack <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      op_hold <= op_hold_n;
      op_pc   <= op_pc_n;
      pending <= pending_n;
      instrD  <= instr_n;
      pcD     <= pcd_n;
      Imm_D   <= imm_n;
      int_pc  <= int_pc_n;
      int_ack <= int_ack_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating count of edges that load a bubble into IF/ID
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt <= 8'h00;
    end else if (bubble_c && bubble_cnt != 8'hFF) begin
      bubble_cnt <= 8'(bubble_cnt + 8'd1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench for fetch_cycle with a behavioural instruction memory.
module tb_fetch_cycle;

  logic       clk = 1'b0;
  logic       reset;
  logic       interrupt;
  logic       IR_en;
  logic       FlushD;
  logic       jmp_enD;
  logic [7:0] jmp_target;
  logic       RET_enWB;
  logic [7:0] ret_pc;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic [7:0] instrD;
  logic [7:0] pcD;
  logic [7:0] Imm_D;
  logic [7:0] int_pc;
  logic       int_ack;
`ifdef FETCH_PERF_CNT_EN
  logic [7:0] bubble_cnt;
`endif

  logic [7:0] mem [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_cycle dut (
    .clk        (clk),
    .reset      (reset),
    .interrupt  (interrupt),
    .IR_en      (IR_en),
    .FlushD     (FlushD),
    .jmp_enD    (jmp_enD),
    .jmp_target (jmp_target),
    .RET_enWB   (RET_enWB),
    .ret_pc     (ret_pc),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instrD     (instrD),
    .pcD        (pcD),
    .Imm_D      (Imm_D),
    .int_pc     (int_pc),
`ifdef FETCH_PERF_CNT_EN
    .bubble_cnt (bubble_cnt),
`endif
    .int_ack    (int_ack)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h80;
    mem[8'h10] = 8'h21; mem[8'h11] = 8'hC4; mem[8'h12] = 8'h5A;
    mem[8'h13] = 8'hC7; mem[8'h14] = 8'h99;
    mem[8'h20] = 8'hC1; mem[8'h21] = 8'h77; mem[8'h22] = 8'h66;
    mem[8'h33] = 8'h12;
    mem[8'h40] = 8'h42; mem[8'h41] = 8'h55;
    mem[8'h80] = 8'hE0; mem[8'h81] = 8'h17;
    mem[8'hFF] = 8'h23;

    reset = 1'b0; interrupt = 1'b0; IR_en = 1'b1; FlushD = 1'b0;
    jmp_enD = 1'b0; jmp_target = 8'h00; RET_enWB = 1'b0; ret_pc = 8'h00;
    tick(); tick();
    chk("rst_instr", instrD, 8'h00);
    chk("rst_pcD", pcD, 8'h00);
    chk("rst_imm", Imm_D, 8'h00);
    chk("rst_int_pc", int_pc, 8'h00);
    chk("rst_ack", {7'd0, int_ack}, 8'h00);
    chk("rst_addr", imem_addr, 8'h00);

    // Boot: vector load then first fetch from 0x10
    reset = 1'b1;
    tick();
    chk("boot_nop", instrD, 8'h00);
    chk("boot_addr", imem_addr, 8'h10);
`ifdef FETCH_PERF_CNT_EN
    chk("boot_bcnt", bubble_cnt, 8'h01);
`endif
    tick();
    chk("f1_instr", instrD, 8'h21);
    chk("f1_pcD", pcD, 8'h10);
    chk("f1_imm", Imm_D, 8'h00);
    chk("f1_addr", imem_addr, 8'h11);

    // Two-byte C4 5A with a 3-cycle stall between the bytes
    tick();
    chk("imm_nop", instrD, 8'h00);
    chk("imm_addr", imem_addr, 8'h12);
    IR_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instrD, 8'h00);
      chk("stall_addr", imem_addr, 8'h12);
    end
    IR_en = 1'b1;
    tick();
    chk("two_instr", instrD, 8'hC4);
    chk("two_pcD", pcD, 8'h11);
    chk("two_imm", Imm_D, 8'h5A);
    chk("two_addr", imem_addr, 8'h13);

    // Jump with IR_en low abandons a half-fetched C7
    tick();
    chk("imm2_nop", instrD, 8'h00);
    chk("imm2_addr", imem_addr, 8'h14);
    IR_en = 1'b0; jmp_enD = 1'b1; jmp_target = 8'h40;
    tick();
    chk("jmp_nop", instrD, 8'h00);
    chk("jmp_addr", imem_addr, 8'h40);
    IR_en = 1'b1; jmp_enD = 1'b0;
    tick();
    chk("j1_instr", instrD, 8'h42);
    chk("j1_pcD", pcD, 8'h40);
    tick();
    chk("j2_instr", instrD, 8'h55);
    chk("j2_pcD", pcD, 8'h41);
    chk("j2_imm", Imm_D, 8'h00);

    // Interrupt pulsed mid two-byte instruction at 0x20
    jmp_enD = 1'b1; jmp_target = 8'h20;
    tick();
    jmp_enD = 1'b0;
    tick();
    chk("i_imm_addr", imem_addr, 8'h21);
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    chk("i_instr", instrD, 8'hC1);
    chk("i_pcD", pcD, 8'h20);
    chk("i_imm", Imm_D, 8'h77);
    chk("i_noack", {7'd0, int_ack}, 8'h00);
    tick();
    chk("i_ack", {7'd0, int_ack}, 8'h01);
    chk("i_int_pc", int_pc, 8'h22);
    chk("i_nop", instrD, 8'h00);
    chk("i_vec_addr", imem_addr, 8'h01);
    tick();
    chk("i_ack_off", {7'd0, int_ack}, 8'h00);
    chk("i_isr_addr", imem_addr, 8'h80);
    tick();
    chk("isr_instr", instrD, 8'hE0);
    chk("isr_pcD", pcD, 8'h80);

    // RET beats jump and interrupt in the same cycle
    RET_enWB = 1'b1; ret_pc = 8'h33; jmp_enD = 1'b1; jmp_target = 8'h50; interrupt = 1'b1;
    tick();
    RET_enWB = 1'b0; jmp_enD = 1'b0; interrupt = 1'b0;
    chk("pri_addr", imem_addr, 8'h33);
    chk("pri_ack", {7'd0, int_ack}, 8'h00);
    chk("pri_nop", instrD, 8'h00);
    tick();
    chk("pri_take", {7'd0, int_ack}, 8'h01);
    chk("pri_int_pc", int_pc, 8'h33);
    tick();
    chk("pri_isr", imem_addr, 8'h80);

    // FlushD refetches the same byte
    tick();
    chk("pf_instr", instrD, 8'hE0);
    FlushD = 1'b1;
    tick();
    FlushD = 1'b0;
    chk("fl_nop", instrD, 8'h00);
    chk("fl_addr", imem_addr, 8'h81);
    tick();
    chk("fl_instr", instrD, 8'h17);
    chk("fl_pcD", pcD, 8'h81);

    // PC wraps from 0xFF to 0x00
    jmp_enD = 1'b1; jmp_target = 8'hFF;
    tick();
    jmp_enD = 1'b0;
    tick();
    chk("wr_instr", instrD, 8'h23);
    chk("wr_pcD", pcD, 8'hFF);
    chk("wr_addr", imem_addr, 8'h00);
    tick();
    chk("wr2_instr", instrD, 8'h10);
    chk("wr2_pcD", pcD, 8'h00);

    // Reset asserted while waiting for an immediate
    jmp_enD = 1'b1; jmp_target = 8'h20;
    tick();
    jmp_enD = 1'b0;
    tick();
    chk("mr_imm_addr", imem_addr, 8'h21);
    reset = 1'b0;
    tick();
    chk("mr_instr", instrD, 8'h00);
    chk("mr_pcD", pcD, 8'h00);
    chk("mr_imm", Imm_D, 8'h00);
    chk("mr_int_pc", int_pc, 8'h00);
    chk("mr_ack", {7'd0, int_ack}, 8'h00);
    chk("mr_addr", imem_addr, 8'h00);
`ifdef FETCH_PERF_CNT_EN
    chk("mr_bcnt", bubble_cnt, 8'h00);
`endif
    reset = 1'b1;
    tick();
    tick();
    chk("rb_instr", instrD, 8'h21);
    chk("rb_pcD", pcD, 8'h10);

`ifdef FETCH_PERF_CNT_EN
    // Bubble counter saturates under a long flush
    FlushD = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    FlushD = 1'b0;
    chk("bcnt_sat", bubble_cnt, 8'hFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
